pkt_write_control: RTL

Write-side counterpart of the per-port packet read path. It sits between network_rx and the PCB / pkt_centralize_bufm_memory.
- Prefetches a free pkt_bufid from the PCB.
- Writes each received packet word to memory at {pkt_bufid, 7-bit word offset}, using a wr/ack handshake.
- Emits a 57-bit packet descriptor (bufid in [8:0]) to the forwarding/queue stage once the tail word has been written.

One instance per network interface.

---
 rtl/pkt_write_control_pkg.sv | 37 +++
 rtl/pkt_write_control.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pkt_write_control_pkg.sv
// Shared constants for the packet write/read paths and descriptor consumers.
// Word layout, descriptor field offsets and the write-control FSM encoding.
package pkt_write_control_pkg;

  localparam int DATA_W        = 134;
  localparam int HEAD_BIT      = 133;
  localparam int TAIL_BIT      = 132;
  localparam int MAX_PKT_WORDS = 128;

  localparam int BUFID_W  = 9;
  localparam int OFFSET_W = 8;
  localparam int ADDR_W   = 16;
  localparam int ERR_W    = 16;

  localparam int DESC_W         = 57;
  localparam int DESC_BUFID_LSB = 0;
  localparam int DESC_CNT_LSB   = 9;
  localparam int DESC_HDR_LSB   = 17;
  localparam int HDR_DATA_MSB   = 127;
  localparam int HDR_DATA_LSB   = 88;
  localparam int HDR_W          = HDR_DATA_MSB - HDR_DATA_LSB + 1;

  typedef enum logic [2:0] {
    FETCH_S = 3'd0,
    IDLE_S  = 3'd1,
    WRITE_S = 3'd2,
    DROP_S  = 3'd3,
    DESC_S  = 3'd4
  } pwc_state_e;

  // Buffer memory address: bufid selects the 128-word page, offset[6:0] the word.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [BUFID_W-1:0]  bufid,
                                                  input logic [OFFSET_W-1:0] offset);
    return {bufid, offset[6:0]};
  endfunction

endpackage

// File: rtl/pkt_write_control.sv
// Per-port packet write path: prefetches a free bufid, writes packet words into
// buffer memory with a wr/ack handshake and emits a descriptor after the tail.
module pkt_write_control
  import pkt_write_control_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DATA_W-1:0]   iv_pkt_data,
  input  logic                i_pkt_data_wr,
  output logic                o_pkt_data_ready,
  output logic                o_pkt_bufid_req,
  input  logic [BUFID_W-1:0]  iv_pkt_bufid,
  input  logic                i_pkt_bufid_wr,
  output logic [ADDR_W-1:0]   ov_pkt_waddr,
  output logic [DATA_W-1:0]   ov_pkt_wdata,
  output logic                o_pkt_wr,
  input  logic                i_pkt_waddr_ack,
  output logic [DESC_W-1:0]   ov_pkt_descriptor,
  output logic                o_pkt_descriptor_wr,
  input  logic                i_pkt_descriptor_ack,
  output logic [ERR_W-1:0]    ov_pkt_err_cnt,
  output logic [2:0]          ov_pwc_state
);

  localparam logic [OFFSET_W-1:0] MAX_OFFSET = OFFSET_W'(MAX_PKT_WORDS);

  pwc_state_e            state_reg;
  logic [BUFID_W-1:0]    bufid_reg;
  logic [OFFSET_W-1:0]   offset_reg;
  logic                  tail_seen_reg;
  logic [7:0]            cnt_reg;
  logic [HDR_W-1:0]      hdr_reg;
  logic                  bufid_req_reg;
  logic                  pkt_wr_reg;
  logic                  desc_wr_reg;
  logic [ADDR_W-1:0]     waddr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [ERR_W-1:0]      err_cnt_reg;

  logic data_ready;
  logic accept;
  logic head;
  logic tail;
  logic wr_done;
  logic start_pkt;
  logic err_inc;

  assign head    = iv_pkt_data[HEAD_BIT];
  assign tail    = iv_pkt_data[TAIL_BIT];
  assign accept  = i_pkt_data_wr & data_ready;
  assign wr_done = pkt_wr_reg & i_pkt_waddr_ack;

  always_comb begin
    data_ready = 1'b0;
    case (state_reg)
      IDLE_S, DROP_S: data_ready = 1'b1;
      WRITE_S:        data_ready = !tail_seen_reg && (!pkt_wr_reg || i_pkt_waddr_ack);
      default:        data_ready = 1'b0;
    endcase
  end

  // A head restarts the packet in the same buffer, whether from IDLE or as an abort.
  assign start_pkt = accept && head && (state_reg == IDLE_S || state_reg == WRITE_S);
  assign err_inc   = accept && (((state_reg == IDLE_S) && !head) ||
                                ((state_reg == WRITE_S) && (head || offset_reg == MAX_OFFSET)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= FETCH_S;
      bufid_reg     <= '0;
      offset_reg    <= '0;
      tail_seen_reg <= 1'b0;
      cnt_reg       <= '0;
      hdr_reg       <= '0;
      bufid_req_reg <= 1'b0;
      pkt_wr_reg    <= 1'b0;
      desc_wr_reg   <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (wr_done) pkt_wr_reg <= 1'b0;

      case (state_reg)
        FETCH_S: begin
          if (!bufid_req_reg) begin
            bufid_req_reg <= 1'b1;
          end else if (i_pkt_bufid_wr) begin
            bufid_reg     <= iv_pkt_bufid;
            bufid_req_reg <= 1'b0;
            state_reg     <= IDLE_S;
          end
        end
        IDLE_S: ;
        WRITE_S: begin
          if (accept && !head) begin
            if (offset_reg == MAX_OFFSET) begin
              // Oversize: a tail arriving here has nothing left to drop after it.
              state_reg <= tail ? IDLE_S : DROP_S;
            end else begin
              pkt_wr_reg <= 1'b1;
              waddr_reg  <= word_addr(bufid_reg, offset_reg);
              wdata_reg  <= iv_pkt_data;
              offset_reg <= offset_reg + 8'd1;
              if (tail) begin
                tail_seen_reg <= 1'b1;
                cnt_reg       <= offset_reg + 8'd1;
              end
            end
          end else if (wr_done && tail_seen_reg) begin
            desc_wr_reg <= 1'b1;
            state_reg   <= DESC_S;
          end
        end
        DROP_S: begin
          if (accept && tail) state_reg <= IDLE_S;
        end
        DESC_S: begin
          if (i_pkt_descriptor_ack) begin
            desc_wr_reg   <= 1'b0;
            bufid_req_reg <= 1'b1;
            state_reg     <= FETCH_S;
          end
        end
        default: state_reg <= FETCH_S;
      endcase

      if (start_pkt) begin
        pkt_wr_reg    <= 1'b1;
        waddr_reg     <= word_addr(bufid_reg, '0);
        wdata_reg     <= iv_pkt_data;
        offset_reg    <= 8'd1;
        hdr_reg       <= iv_pkt_data[HDR_DATA_MSB:HDR_DATA_LSB];
        tail_seen_reg <= tail;
        cnt_reg       <= 8'd1;
        state_reg     <= WRITE_S;
      end

      if (err_inc) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign o_pkt_data_ready    = data_ready;
  assign o_pkt_bufid_req     = bufid_req_reg;
  assign ov_pkt_waddr        = waddr_reg;
  assign ov_pkt_wdata        = wdata_reg;
  assign o_pkt_wr            = pkt_wr_reg;
  assign ov_pkt_descriptor   = {hdr_reg, cnt_reg, bufid_reg};
  assign o_pkt_descriptor_wr = desc_wr_reg;
  assign ov_pkt_err_cnt      = err_cnt_reg;
  assign ov_pwc_state        = state_reg;

endmodule
